tdm_mux8: RTL and testbench
===========================

Name: tdm_mux8

Overview:
- 8-to-1 time-division multiplexer/serializer. The transmit-side counterpart of the 1-to-8 demultiplexer already in the design.
- Accepts one 8-channel word through a valid/ready handshake, then emits the channels one per enabled clock on a single output.
- Drives a matching 3-bit channel select alongside each emitted channel, so a downstream 1-to-8 demux fed with (y, s, y_valid as enable) reconstructs the word.

Parameters:
- CH_W, 1, bits per channel; d is 8*CH_W wide, y is CH_W wide.
- LSB_FIRST, 1, 1 = channel 0 is d[CH_W-1:0] and is emitted first; 0 = channel 0 is d[8*CH_W-1:7*CH_W].

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; low freezes the frame and blanks the outputs.
- d  in  8*CH_W  parallel channel word.
- d_valid  in  1  d holds a word to transmit.
- d_ready  out  1  combinational; word is accepted on an edge where d_valid & d_ready.
- y  out  CH_W  registered; current channel data.
- s  out  3  registered; channel index of y.
- y_valid  out  1  registered; y/s carry a live channel.
- frame  out  1  registered; high with channel 0 of each word.
- busy  out  1  high in state SEND.

Behaviour:
- Reset is synchronous: rst high at a rising edge wins over all other inputs.
  - State goes to IDLE; buf and ptr are cleared to 0.
  - y = 0, s = 0, y_valid = 0, frame = 0.
  - Reset mid-frame discards the remaining channels. There is no partial-frame recovery.
- Internal registers:
  - buf: captured word, 8*CH_W bits.
  - ptr: next channel to emit, 3 bits.
  - state: IDLE or SEND.
- d_ready = en & ~rst & (state==IDLE | (state==SEND & ptr==7)).
- Edge with en=0 (and no rst):
  - state, buf and ptr hold.
  - y <= 0, y_valid <= 0, frame <= 0; s holds its last value.
  - No word is accepted.
- IDLE, en=1:
  - If d_valid: buf <= d, ptr <= 0, state <= SEND; outputs stay y_valid=0, y=0.
  - Else: state is unchanged and y_valid <= 0.
- SEND, en=1:
  - Outputs: y <= channel ptr of buf, s <= ptr, y_valid <= 1, frame <= (ptr==0), ptr <= ptr+1.
  - ptr wraps 7 -> 0.
  - When ptr==7 and d_valid: in the same edge channel 7 is emitted from the old buf, and buf <= d, ptr <= 0, state stays SEND.
  - When ptr==7 and not d_valid: channel 7 is emitted, then state <= IDLE.
- Latency:
  - Accept from IDLE at edge k: channel 0 appears after edge k+1, channel 7 after edge k+8 (all en=1).
  - Back-to-back words give continuous output with no bubble, 8 enabled cycles per word.
- en low mid-frame: the next emitted channel on resume is ptr. No channel is skipped or repeated.
- d and d_valid are ignored while d_ready is low. The source must hold d/d_valid until accepted.
- s is meaningful only when y_valid=1.
- busy = (state==SEND).

Test Plan:
- Reset and idle: rst=1 for 2 cycles with d_valid=1 -> y=0, s=0, y_valid=0, frame=0, busy=0; d_ready=0 while rst=1.
- Single word, CH_W=1, LSB_FIRST=1, d=8'b1011_0010 accepted at edge k -> over edges k+1..k+8, s=0..7 and y=0,1,0,0,1,1,0,1; frame=1 only at s=0; y_valid drops after edge k+9; busy=0.
- Back-to-back: 8'hA5 then 8'h3C, d_valid held high -> d_ready pulses at ptr==7; 16 consecutive y_valid=1 cycles; frame=1 at cycles 1 and 9; second word bits are 0,0,1,1,1,1,0,0.
- Enable gap: drop en for 3 cycles after s=2 is emitted -> y_valid=0, y=0, s stays 2, no accept; on en=1 the next output is s=3 with the correct bit, and the word completes intact.
- Reset mid-frame: rst=1 after s=4 -> next cycle all outputs 0 and busy=0; a new word 8'hFF is then accepted and emitted from s=0.
- Loopback: connect y/s/y_valid to the 1-to-8 demux (a, s, en) with a capture register, CH_W=1, 200 random words with random en/d_valid gaps -> every reassembled word equals the sent word, in order.

Source files
------------

// File: rtl/tdm_mux8.sv
// 8-to-1 time-division serializer: takes one 8-channel word by valid/ready
// and emits one channel per enabled clock with its matching 3-bit select.
module tdm_mux8 #(
  parameter int CH_W      = 1,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [8*CH_W-1:0] d,
  input  logic              d_valid,
  output logic              d_ready,
  output logic [CH_W-1:0]   y,
  output logic [2:0]        s,
  output logic              y_valid,
  output logic              frame,
  output logic              busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state, state_nxt;
  logic [8*CH_W-1:0]   word_buf, word_buf_nxt;
  logic [2:0]          ptr, ptr_nxt;
  logic [CH_W-1:0]     y_nxt;
  logic [2:0]          s_nxt;
  logic                y_valid_nxt, frame_nxt;
  logic [CH_W-1:0]     chans [8];
  logic                last, accept;

  // Channel numbering is fixed here so the emit path only indexes by ptr.
  for (genvar i = 0; i < 8; i++) begin : g_chan
    localparam int SLOT = LSB_FIRST ? i : 7 - i;
    assign chans[i] = word_buf[SLOT*CH_W +: CH_W];
  end

  assign last    = (ptr == 3'd7);
  assign d_ready = en & ~rst & ((state == IDLE) | ((state == SEND) & last));
  assign accept  = d_valid & d_ready;
  assign busy    = (state == SEND);

  always_comb begin
    state_nxt    = state;
    word_buf_nxt = word_buf;
    ptr_nxt      = ptr;
    y_nxt        = '0;
    s_nxt        = s;
    y_valid_nxt  = 1'b0;
    frame_nxt    = 1'b0;
    if (en) begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            word_buf_nxt = d;
            ptr_nxt      = 3'd0;
            state_nxt    = SEND;
          end
        end
        SEND: begin
          y_nxt       = chans[ptr];
          s_nxt       = ptr;
          y_valid_nxt = 1'b1;
          frame_nxt   = (ptr == 3'd0);
          ptr_nxt     = ptr + 3'd1;
          // Reloading on the last channel keeps back-to-back words bubble-free.
          if (last) begin
            if (accept) word_buf_nxt = d;
            else        state_nxt    = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      word_buf <= '0;
      ptr      <= 3'd0;
      y        <= '0;
      s        <= 3'd0;
      y_valid  <= 1'b0;
      frame    <= 1'b0;
    end else begin
      state    <= state_nxt;
      word_buf <= word_buf_nxt;
      ptr      <= ptr_nxt;
      y        <= y_nxt;
      s        <= s_nxt;
      y_valid  <= y_valid_nxt;
      frame    <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_tdm_mux8.sv
// Bench for tdm_mux8 (CH_W=1, LSB first): directed scenarios plus a randomized
// loopback that reassembles words the way a downstream 1-to-8 demux would.
module tb_tdm_mux8;

  logic       clk = 1'b0;
  logic       rst, en, d_valid;
  logic [7:0] d;
  logic       d_ready, y, y_valid, frame, busy;
  logic [2:0] s;

  int pass_cnt  = 0;
  int check_cnt = 0;

  tdm_mux8 #(.CH_W(1), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .d(d), .d_valid(d_valid), .d_ready(d_ready),
    .y(y), .s(s), .y_valid(y_valid), .frame(frame), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; d_valid = 1'b1; d = 8'($urandom);
    #1;
    check_cnt++;
    if (d_ready !== 1'b0) $display("[TB] FAIL reset_d_ready: got %b expected 0", d_ready);
    else pass_cnt++;
    tick(); tick();
    check_cnt++;
    if ({y, s, y_valid, frame, busy} !== 7'b0)
      $display("[TB] FAIL reset_outputs: got y=%b s=%0d v=%b f=%b busy=%b expected all 0", y, s, y_valid, frame, busy);
    else pass_cnt++;
    check_cnt++;
    if (d_ready !== 1'b0) $display("[TB] FAIL reset_d_ready_held: got %b expected 0", d_ready);
    else pass_cnt++;
    rst = 1'b0; d_valid = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] w;
    logic [5:0] exp_o;
    w = 8'b1011_0010;
    d = w; d_valid = 1'b1; en = 1'b1;
    #1;
    check_cnt++;
    if (d_ready !== 1'b1) $display("[TB] FAIL single_ready: got %b expected 1", d_ready);
    else pass_cnt++;
    tick();
    d_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_o = {w[i], i[2:0], 1'b1, i == 0};
      check_cnt++;
      if ({y, s, y_valid, frame} !== exp_o)
        $display("[TB] FAIL single_ch%0d: got {y,s,v,f}=%b expected %b", i, {y, s, y_valid, frame}, exp_o);
      else pass_cnt++;
    end
    check_cnt++;
    if (busy !== 1'b0) $display("[TB] FAIL single_busy_end: got %b expected 0", busy);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (y_valid !== 1'b0) $display("[TB] FAIL single_valid_drop: got %b expected 0", y_valid);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] wa, wb;
    logic [5:0] exp_o;
    logic       exp_y;
    wa = 8'hA5; wb = 8'h3C;
    d = wa; d_valid = 1'b1; en = 1'b1;
    tick();
    d = wb;
    for (int i = 1; i <= 16; i++) begin
      #1;
      check_cnt++;
      if (d_ready !== ((i == 8) || (i == 16)))
        $display("[TB] FAIL b2b_ready_%0d: got %b expected %b", i, d_ready, (i == 8) || (i == 16));
      else pass_cnt++;
      tick();
      if (i == 8) d_valid = 1'b0;
      exp_y = (i <= 8) ? wa[i-1] : wb[i-9];
      exp_o = {exp_y, 3'(i - 1), 1'b1, (i == 1) || (i == 9)};
      check_cnt++;
      if ({y, s, y_valid, frame} !== exp_o)
        $display("[TB] FAIL b2b_cycle%0d: got {y,s,v,f}=%b expected %b", i, {y, s, y_valid, frame}, exp_o);
      else pass_cnt++;
    end
    tick();
    check_cnt++;
    if ({y_valid, busy} !== 2'b00) $display("[TB] FAIL b2b_end: got v,busy=%b expected 00", {y_valid, busy});
    else pass_cnt++;
  endtask

  task automatic test_enable_gap();
    logic [7:0] w;
    logic [5:0] exp_o;
    w = 8'($urandom);
    d = w; d_valid = 1'b1; en = 1'b1;
    tick();
    d_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_o = {w[i], i[2:0], 1'b1, i == 0};
      check_cnt++;
      if ({y, s, y_valid, frame} !== exp_o)
        $display("[TB] FAIL gap_pre_ch%0d: got %b expected %b", i, {y, s, y_valid, frame}, exp_o);
      else pass_cnt++;
    end
    en = 1'b0; d_valid = 1'b1; d = ~w;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_cnt++;
      if (d_ready !== 1'b0) $display("[TB] FAIL gap_ready_%0d: got %b expected 0", i, d_ready);
      else pass_cnt++;
      tick();
      check_cnt++;
      if ({y, s, y_valid, frame} !== {1'b0, 3'd2, 1'b0, 1'b0})
        $display("[TB] FAIL gap_hold_%0d: got {y,s,v,f}=%b expected 001000", i, {y, s, y_valid, frame});
      else pass_cnt++;
    end
    en = 1'b1; d_valid = 1'b0; d = w;
    for (int i = 3; i < 8; i++) begin
      tick();
      exp_o = {w[i], i[2:0], 1'b1, 1'b0};
      check_cnt++;
      if ({y, s, y_valid, frame} !== exp_o)
        $display("[TB] FAIL gap_post_ch%0d: got %b expected %b", i, {y, s, y_valid, frame}, exp_o);
      else pass_cnt++;
    end
    tick();
  endtask

  task automatic test_reset_mid();
    d = 8'($urandom); d_valid = 1'b1; en = 1'b1;
    tick();
    d_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    check_cnt++;
    if ({y, s, y_valid, frame, busy} !== 7'b0)
      $display("[TB] FAIL midreset_outputs: got y=%b s=%0d v=%b f=%b busy=%b expected all 0", y, s, y_valid, frame, busy);
    else pass_cnt++;
    rst = 1'b0; d = 8'hFF; d_valid = 1'b1;
    #1;
    check_cnt++;
    if (d_ready !== 1'b1) $display("[TB] FAIL midreset_ready: got %b expected 1", d_ready);
    else pass_cnt++;
    tick();
    d_valid = 1'b0;
    tick();
    check_cnt++;
    if ({y, s, y_valid, frame} !== {1'b1, 3'd0, 1'b1, 1'b1})
      $display("[TB] FAIL midreset_restart: got {y,s,v,f}=%b expected 100011", {y, s, y_valid, frame});
    else pass_cnt++;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_loopback();
    logic [7:0] sent_q [$];
    logic [7:0] cap, expw;
    logic [2:0] exp_s;
    logic       pending, acc;
    int         sent, recv, cycles;
    sent = 0; recv = 0; cycles = 0; pending = 1'b0; exp_s = 3'd0; cap = 8'h00;
    d_valid = 1'b0;
    while (recv < 200 && cycles < 20000) begin
      en = ($urandom_range(0, 4) != 0);
      if (!pending && sent < 200 && $urandom_range(0, 2) != 0) begin
        d = 8'($urandom); d_valid = 1'b1; pending = 1'b1;
      end
      #1;
      acc = en && d_valid && d_ready;
      if (acc) sent_q.push_back(d);
      tick();
      cycles++;
      if (acc) begin
        d_valid = 1'b0; pending = 1'b0; sent++;
      end
      if (y_valid === 1'b1) begin
        check_cnt++;
        if ({s, frame} !== {exp_s, exp_s == 3'd0})
          $display("[TB] FAIL loop_select: got s=%0d f=%b expected s=%0d f=%b", s, frame, exp_s, exp_s == 3'd0);
        else pass_cnt++;
        cap[exp_s] = y;
        if (exp_s == 3'd7) begin
          check_cnt++;
          if (sent_q.size() == 0) begin
            $display("[TB] FAIL loop_word%0d: got %h expected no word", recv, cap);
          end else begin
            expw = sent_q.pop_front();
            if (cap !== expw) $display("[TB] FAIL loop_word%0d: got %h expected %h", recv, cap, expw);
            else pass_cnt++;
          end
          recv++;
        end
        exp_s = exp_s + 3'd1;
      end
    end
    check_cnt++;
    if (recv < 200) $display("[TB] FAIL loop_timeout: got %0d words expected 200", recv);
    else pass_cnt++;
    en = 1'b1; d_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; d_valid = 1'b0; d = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_enable_gap();
    test_reset_mid();
    test_loopback();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
